// File: rtl/rv32_pkg.sv
// Shared RV32 types and sizes used by the integer register file.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_X0 = '0;

endpackage

// File: rtl/reg_file_rdport.sv
// Combinational read port: selects one register, x0 always reads as zero.
module reg_file_rdport
  import rv32_pkg::*;
(
  input  reg_addr_t addr,
  input  word_t     regs [1:NREGS-1],
  output word_t     data
);

  always_comb begin
    data = '0;
    if (addr != REG_X0) data = regs[addr];
  end

endmodule

// File: rtl/reg_file.sv
// RV32I register file: x1..x31 storage, two zero-latency read ports, one write port.
module reg_file
  import rv32_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  reg_addr_t rsw,
  input  word_t     data_in,
  input  logic      RegWEn,
  output word_t     data_out_1,
  output word_t     data_out_2
);

  word_t regs_q [1:NREGS-1];
  word_t regs_d [1:NREGS-1];

  // Writes to x0 are dropped here, so x0 needs no storage at all.
  always_comb begin
    regs_d = regs_q;
    if (RegWEn && (rsw != REG_X0)) regs_d[rsw] = data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: reads see the stored value until the edge commits it.
  reg_file_rdport u_rdport_1 (
    .addr (rs1),
    .regs (regs_q),
    .data (data_out_1)
  );

  reg_file_rdport u_rdport_2 (
    .addr (rs2),
    .regs (regs_q),
    .data (data_out_2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run against an array model.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, rsw;
  logic [31:0] data_in;
  logic        RegWEn;
  logic [31:0] data_out_1, data_out_2;

  int passed = 0;
  int total  = 0;

  // Reference model: architectural register contents, entry 0 stays zero.
  logic [31:0] model [32];

  reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .rs1        (rs1),
    .rs2        (rs2),
    .rsw        (rsw),
    .data_in    (data_in),
    .RegWEn     (RegWEn),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expect_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic we);
    @(negedge clk);
    rsw = a; data_in = d; RegWEn = we;
    @(posedge clk);
    if (we && a != 5'd0) model[a] = d;
    #1;
    RegWEn = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (data_out_1 !== 32'd0) $display("[TB] FAIL reset_during: data_out_1=%h required 0", data_out_1);
    else passed++;
    @(posedge clk); #2;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0];
      #1;
      total++;
      if (data_out_1 !== 32'd0) $display("[TB] FAIL reset_read x%0d: data_out_1=%h required 0", i, data_out_1);
      else passed++;
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'd42, 1'b1);
    rs1 = 5'd5; rs2 = 5'd0;
    #1;
    total++;
    if (data_out_1 !== 32'd42) $display("[TB] FAIL wr_x5: data_out_1=%h required %h", data_out_1, 32'd42);
    else passed++;
    total++;
    if (data_out_2 !== 32'd0) $display("[TB] FAIL wr_x0_port2: data_out_2=%h required 0", data_out_2);
    else passed++;
  endtask

  task automatic test_second_reg();
    do_write(5'd7, 32'd62, 1'b1);
    rs1 = 5'd7; rs2 = 5'd5;
    #1;
    total++;
    if (data_out_1 !== 32'd62) $display("[TB] FAIL wr_x7: data_out_1=%h required %h", data_out_1, 32'd62);
    else passed++;
    total++;
    if (data_out_2 !== 32'd42) $display("[TB] FAIL alias_x5: data_out_2=%h required %h", data_out_2, 32'd42);
    else passed++;
  endtask

  task automatic test_x0();
    do_write(5'd0, 32'd123, 1'b1);
    rs1 = 5'd0; rs2 = 5'd0;
    #1;
    total++;
    if (data_out_1 !== 32'd0) $display("[TB] FAIL x0_write: data_out_1=%h required 0", data_out_1);
    else passed++;
  endtask

  task automatic test_enable();
    for (int i = 0; i < 4; i++) do_write(5'd9, 32'hDEADBEEF, 1'b0);
    rs1 = 5'd9; rs2 = 5'd7;
    #1;
    total++;
    if (data_out_1 !== 32'd0) $display("[TB] FAIL we_gate_x9: data_out_1=%h required 0", data_out_1);
    else passed++;
    total++;
    if (data_out_2 !== 32'd62) $display("[TB] FAIL we_gate_x7: data_out_2=%h required %h", data_out_2, 32'd62);
    else passed++;
  endtask

  task automatic test_rdw_async();
    @(negedge clk);
    rs1 = 5'd3; rsw = 5'd3; data_in = 32'h55; RegWEn = 1'b1;
    #1;
    total++;
    if (data_out_1 !== 32'd0) $display("[TB] FAIL rdw_before: data_out_1=%h required 0", data_out_1);
    else passed++;
    @(posedge clk); #1;
    RegWEn = 1'b0;
    total++;
    if (data_out_1 !== 32'h55) $display("[TB] FAIL rdw_after: data_out_1=%h required %h", data_out_1, 32'h55);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if (data_out_1 !== 32'd0) $display("[TB] FAIL async_rst: data_out_1=%h required 0", data_out_1);
    else passed++;
    rs1 = 5'd7;
    #1;
    total++;
    if (data_out_1 !== 32'd0) $display("[TB] FAIL async_rst_x7: data_out_1=%h required 0", data_out_1);
    else passed++;
    model_clear();
    // Write attempted across an edge while reset is held: reset must win.
    @(negedge clk);
    rs1 = 5'd3; rsw = 5'd3; data_in = 32'h77; RegWEn = 1'b1;
    @(posedge clk); #1;
    total++;
    if (data_out_1 !== 32'd0) $display("[TB] FAIL rst_wins: data_out_1=%h required 0", data_out_1);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if (data_out_1 !== 32'd0) $display("[TB] FAIL rst_release_no_edge: data_out_1=%h required 0", data_out_1);
    else passed++;
    @(posedge clk); #1;
    RegWEn = 1'b0;
    model[3] = 32'h77;
    total++;
    if (data_out_1 !== 32'h77) $display("[TB] FAIL first_write_after_rst: data_out_1=%h required %h", data_out_1, 32'h77);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rsw     = $urandom_range(0, 31);
      rs1     = ($urandom_range(0, 3) == 0) ? rsw : 5'($urandom_range(0, 31));
      rs2     = $urandom_range(0, 31);
      data_in = $urandom;
      RegWEn  = ($urandom_range(0, 2) != 0);
      #1;
      e1 = expect_read(rs1); e2 = expect_read(rs2);
      total++;
      if (data_out_1 !== e1 || data_out_2 !== e2)
        $display("[TB] FAIL rand_pre n=%0d: out1=%h out2=%h required %h %h", n, data_out_1, data_out_2, e1, e2);
      else passed++;
      @(posedge clk);
      if (RegWEn && rsw != 5'd0) model[rsw] = data_in;
      #1;
      e1 = expect_read(rs1); e2 = expect_read(rs2);
      total++;
      if (data_out_1 !== e1 || data_out_2 !== e2)
        $display("[TB] FAIL rand_post n=%0d: out1=%h out2=%h required %h %h", n, data_out_1, data_out_2, e1, e2);
      else passed++;
    end
    RegWEn = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rs1 = '0; rs2 = '0; rsw = '0; data_in = '0; RegWEn = 1'b0;
    model_clear();
    test_reset();
    test_write_read();
    test_second_reg();
    test_x0();
    test_enable();
    test_rdw_async();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
